dec_2to4_pulse: RTL and testbench

Registered 2-to-4 one-hot decoder with a valid/ready input handshake and a programmable output pulse width. It accepts a 2-bit code (index 0..3), drives the matching one-hot line for HOLD_CYCLES clocks, and then optionally idles for GAP_CYCLES before accepting the next code. It sits downstream of the 4-to-2 priority encoders. It regenerates one-hot select/strobe lines from encoded indices, for example to drive LEDs, mux selects or request lines.

---
 rtl/dec_pulse_pkg.sv | 14 +
 rtl/dec_2to4_onehot.sv | 10 +
 rtl/dec_2to4_pulse.sv | 89 ++++++++
 tb/tb_dec_2to4_pulse.sv | 134 +++++++++++++
 4 files changed

// File: rtl/dec_pulse_pkg.sv
// Shared encodings for the pulse-stretching 2-to-4 decoder: FSM states,
// one-hot width and the code-to-one-hot helper.
package dec_pulse_pkg;
  localparam int ONEHOT_W = 4;
  localparam int CODE_W   = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  function automatic logic [ONEHOT_W-1:0] onehot4(input logic [CODE_W-1:0] code);
    onehot4 = ONEHOT_W'(1) << code;
  endfunction
endpackage

// File: rtl/dec_2to4_onehot.sv
// Combinational 2-bit code to 4-bit one-hot with an enable; all-zero when disabled.
module dec_2to4_onehot
  import dec_pulse_pkg::*;
(
  input  logic                en,
  input  logic [CODE_W-1:0]   code,
  output logic [ONEHOT_W-1:0] onehot
);
  assign onehot = en ? onehot4(code) : '0;
endmodule

// File: rtl/dec_2to4_pulse.sv
// Registered 2-to-4 one-hot decoder: accepts a code on valid/ready, holds the
// matching line for HOLD_CYCLES clocks, then idles GAP_CYCLES before re-arming.
module dec_2to4_pulse
  import dec_pulse_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [CODE_W-1:0]   in_code,
  output logic                in_ready,
  output logic [ONEHOT_W-1:0] out_onehot,
  output logic                out_active,
  output logic                done
);
  localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]          st, st_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [CODE_W-1:0]   code, code_nxt;
  logic [ONEHOT_W-1:0] oh_nxt;
  logic                done_nxt;

  always_comb begin
    st_nxt   = st;
    cnt_nxt  = cnt;
    code_nxt = code;
    done_nxt = 1'b0;
    case (st)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          st_nxt   = ST_DRIVE;
          cnt_nxt  = HOLD_LD;
          code_nxt = in_code;
        end
      end
      ST_DRIVE: begin
        if (cnt == '0) begin
          done_nxt = 1'b1;
          if (GAP_CYCLES > 0) begin
            st_nxt  = ST_GAP;
            cnt_nxt = GAP_LD;
          end else begin
            st_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == '0) st_nxt = ST_IDLE;
        else           cnt_nxt = cnt - 1'b1;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  // Decode the next-state view so the registered output lines up with DRIVE.
  dec_2to4_onehot u_dec (
    .en    (st_nxt == ST_DRIVE),
    .code  (code_nxt),
    .onehot(oh_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= ST_IDLE;
      cnt        <= '0;
      code       <= '0;
      out_onehot <= '0;
      out_active <= 1'b0;
      done       <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      st         <= st_nxt;
      cnt        <= cnt_nxt;
      code       <= code_nxt;
      out_onehot <= oh_nxt;
      out_active <= (st_nxt == ST_DRIVE);
      done       <= done_nxt;
      in_ready   <= (st_nxt == ST_IDLE);
    end
  end
endmodule

// File: tb/tb_dec_2to4_pulse.sv
// Directed bench for dec_2to4_pulse across three configurations (4/1, 4/0, 1/1).
module tb_dec_2to4_pulse;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v0 = 0, v1 = 0, v2 = 0;
  logic [1:0] c0 = 0, c1 = 0, c2 = 0;
  logic       rdy0, rdy1, rdy2, act0, act1, act2, dn0, dn1, dn2;
  logic [3:0] oh0, oh1, oh2;

  int n_cmp = 0;
  int n_err = 0;

  dec_2to4_pulse #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_code(c0), .in_ready(rdy0),
    .out_onehot(oh0), .out_active(act0), .done(dn0));
  dec_2to4_pulse #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_code(c1), .in_ready(rdy1),
    .out_onehot(oh1), .out_active(act1), .done(dn1));
  dec_2to4_pulse #(.HOLD_CYCLES(1), .GAP_CYCLES(1), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_code(c2), .in_ready(rdy2),
    .out_onehot(oh2), .out_active(act2), .done(dn2));

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b want %b", tag, $time, got, exp);
    end
  endtask

  // Structural invariants, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("inv_oh0_u0", 4'($onehot0(oh0)), 4'd1);
      chk("inv_oh0_u1", 4'($onehot0(oh1)), 4'd1);
      chk("inv_oh0_u2", 4'($onehot0(oh2)), 4'd1);
      chk("inv_rdyact_u0", 4'(rdy0 & act0), 4'd0);
      chk("inv_rdyact_u1", 4'(rdy1 & act1), 4'd0);
      chk("inv_rdyact_u2", 4'(rdy2 & act2), 4'd0);
      chk("inv_act_u0", 4'(act0), 4'(oh0 != 4'd0));
    end
  end

  initial begin
    // Reset held for 3 clocks, then idle for 10
    repeat (3) @(negedge clk);
    chk("rst_oh", oh0, 4'b0000);
    chk("rst_rdy", 4'(rdy0), 4'd1);
    chk("rst_done", 4'(dn0), 4'd0);
    chk("rst_act", 4'(act0), 4'd0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_oh", oh0, 4'b0000);
      chk("idle_rdy", 4'(rdy0), 4'd1);
      chk("idle_done", 4'(dn0), 4'd0);
    end

    // Single decode, code 2, HOLD=4 GAP=1
    v0 = 1'b1; c0 = 2'd2;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      v0 = 1'b0;
      chk("one_oh", oh0, (k <= 4) ? 4'b0100 : 4'b0000);
      chk("one_done", 4'(dn0), (k == 5) ? 4'd1 : 4'd0);
      chk("one_rdy", 4'(rdy0), (k >= 6) ? 4'd1 : 4'd0);
    end

    // Back-to-back codes 0..3, GAP=0
    for (int i = 0; i < 4; i++) begin
      chk("b2b_rdy_pre", 4'(rdy1), 4'd1);
      v1 = 1'b1; c1 = 2'(i);
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        v1 = 1'b0;
        chk("b2b_oh", oh1, (k <= 4) ? (4'b0001 << i) : 4'b0000);
        chk("b2b_done", 4'(dn1), (k == 5) ? 4'd1 : 4'd0);
      end
    end

    // Ignored input while driving code 1; held valid accepted on ready
    v0 = 1'b1; c0 = 2'd1;
    @(negedge clk);
    c0 = 2'd3;
    chk("ign_oh1", oh0, 4'b0010);
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      chk("ign_oh", oh0, (k <= 4) ? 4'b0010 : 4'b0000);
      chk("ign_rdy", 4'(rdy0), (k == 6) ? 4'd1 : 4'd0);
    end
    @(negedge clk);
    v0 = 1'b0;
    chk("ign_accept", oh0, 4'b1000);
    repeat (6) @(negedge clk);
    chk("ign_back_idle", 4'(rdy0), 4'd1);

    // Reset mid-pulse: asserted between edges during the 2nd DRIVE cycle of code 3
    v0 = 1'b1; c0 = 2'd3;
    @(negedge clk);
    v0 = 1'b0;
    chk("rmid_oh_pre", oh0, 4'b1000);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rmid_oh", oh0, 4'b0000);
    chk("rmid_act", 4'(act0), 4'd0);
    chk("rmid_rdy", 4'(rdy0), 4'd1);
    chk("rmid_done", 4'(dn0), 4'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rmid_post_done", 4'(dn0), 4'd0);
      chk("rmid_post_oh", oh0, 4'b0000);
      chk("rmid_post_rdy", 4'(rdy0), 4'd1);
    end

    // HOLD=1 boundary, code 0
    v2 = 1'b1; c2 = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      v2 = 1'b0;
      chk("h1_oh", oh2, (k == 1) ? 4'b0001 : 4'b0000);
      chk("h1_done", 4'(dn2), (k == 2) ? 4'd1 : 4'd0);
      chk("h1_rdy", 4'(rdy2), (k == 3) ? 4'd1 : 4'd0);
    end

    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
